// File: rtl/instruction_slot_controller_pkg.sv
// Shared types for the instruction slot controllers: packets, RF/ALU/MEM
// bundles, ECR encodings and the slot state enum.
package instruction_slot_controller_pkg;

    localparam int PKG_NUM_PHY_REGS = 64;
    localparam int PKG_PR_W         = $clog2(PKG_NUM_PHY_REGS);
    localparam int PKG_ID_WIDTH     = 4;
    localparam int PKG_NUM_ECRS     = 4;
    localparam int PKG_ECR_AW       = (PKG_NUM_ECRS > 1) ? $clog2(PKG_NUM_ECRS) : 1;

    localparam logic [1:0] ECR_BUSY      = 2'b00;
    localparam logic [1:0] ECR_CORRECT   = 2'b01;
    localparam logic [1:0] ECR_INCORRECT = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_READ,
        S_WAIT_ECR,
        S_MEM,
        S_COMMIT,
        S_RELEASE
    } sic_state_t;

    typedef struct packed {
        logic        use_alu;
        logic        use_rs;
        logic        use_rt;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        write_ecr;
        logic        is_jr;
        logic [3:0]  alu_op;
        logic [15:0] imm;
    } sic2_info_t;

    typedef struct packed {
        logic                    valid;
        logic [PKG_ID_WIDTH-1:0] issue_id;
        logic [31:0]             pc;
        logic [PKG_PR_W-1:0]     phy_rs;
        logic [PKG_PR_W-1:0]     phy_rt;
        logic [PKG_PR_W-1:0]     phy_dst;
        logic [PKG_NUM_ECRS-1:0] dep_ecr_mask;
        logic [PKG_ECR_AW-1:0]   set_ecr_id;
        logic                    pred_taken;
        sic2_info_t              info;
    } sic2_packet_t;

    typedef struct packed {
        logic [PKG_PR_W-1:0] rs;
        logic [PKG_PR_W-1:0] rt;
        logic [PKG_PR_W-1:0] waddr;
        logic                wcommit;
        logic [31:0]         wdata;
    } reg_req_t;

    typedef struct packed {
        logic        rs_valid;
        logic        rt_valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } reg_ans_t;

    typedef struct packed {
        logic req;
        logic release_lock;
    } pool_rpl_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
    } mem_req_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
    } alu_ans_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instruction_slot_controller_ecr_dep_checker.sv
// Combinational ECR dependency check shared by all slots: reduces the
// masked ECR states to all-correct and any-incorrect flags.
module ecr_dep_checker
    import instruction_slot_controller_pkg::*;
#(
    parameter int NUM_ECRS = PKG_NUM_ECRS
) (
    input  logic [NUM_ECRS-1:0]   mask,
    input  logic [2*NUM_ECRS-1:0] ecr_state,
    output logic                  all_correct,
    output logic                  any_incorrect
);

    always_comb begin
        all_correct   = 1'b1;
        any_incorrect = 1'b0;
        for (int i = 0; i < NUM_ECRS; i++) begin
            if (mask[i] && ecr_state[2*i +: 2] != ECR_CORRECT)
                all_correct = 1'b0;
            if (mask[i] && ecr_state[2*i +: 2] == ECR_INCORRECT)
                any_incorrect = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_slot_controller.sv
// One issue slot: holds a packet, locks pools, reads operands, waits on
// ECR dependencies and then commits, writes memory or resolves a branch.
module instruction_slot_controller
    import instruction_slot_controller_pkg::*;
#(
    parameter int SIC_ID       = 0,
    parameter int NUM_PHY_REGS = PKG_NUM_PHY_REGS,
    parameter int ID_WIDTH     = PKG_ID_WIDTH,
    parameter int NUM_ECRS     = PKG_NUM_ECRS,
    parameter int MEM_TIMEOUT  = 8,
    localparam int ECR_AW      = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  req_instr,
    input  sic2_packet_t          packet_in,
    output reg_req_t              reg_req,
    input  reg_ans_t              reg_ans,
    output pool_rpl_t             mem_rpl,
    output mem_req_t              mem_req,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_grant,
    output pool_rpl_t             alu_rpl,
    output alu_req_t              alu_req,
    input  alu_ans_t              alu_ans,
    input  logic                  alu_grant,
    input  logic [2*NUM_ECRS-1:0] ecr_state,
    output logic                  ecr_wen,
    output logic [ECR_AW-1:0]     ecr_waddr,
    output logic [1:0]            ecr_wdata,
    input  logic                  flush,
    output logic                  pc_redirect_valid,
    output logic [31:0]           pc_redirect_pc,
    output logic [ID_WIDTH-1:0]   pc_redirect_issue_id,
    output logic [7:0]            mem_retry_cnt
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    sic_state_t   state, state_n;
    sic2_packet_t pkt_q;
    sic2_info_t   info;
    logic [31:0]  rs_q, rt_q, addr_q;
    logic         alu_held;
    logic [CNT_W-1:0] mem_cnt;

    logic held, busy, abort, mem_op, ops_ready;
    logic backoff, mem_on, granted;
    logic commit_alu, commit_mem, commit_ecr, commit_jr;
    logic all_correct, any_incorrect;

    assign info = pkt_q.info;

    ecr_dep_checker #(
        .NUM_ECRS (NUM_ECRS)
    ) u_dep (
        .mask          (pkt_q.dep_ecr_mask),
        .ecr_state     (ecr_state),
        .all_correct   (all_correct),
        .any_incorrect (any_incorrect)
    );

    always_comb begin
        held       = state != S_IDLE;
        busy       = held && state != S_RELEASE;
        abort      = busy && (flush || any_incorrect);
        mem_op     = info.mem_read || info.mem_write;
        ops_ready  = (!info.use_rs  || reg_ans.rs_valid)
                  && (!info.use_rt  || reg_ans.rt_valid)
                  && (!info.use_alu || alu_grant || alu_held);
        backoff    = mem_cnt == CNT_W'(MEM_TIMEOUT);
        mem_on     = state == S_MEM && !backoff;
        granted    = mem_on && mem_grant;
        commit_alu = state == S_COMMIT && info.reg_write && !mem_op && !abort;
        commit_mem = granted && info.mem_read && info.reg_write && !abort;
        commit_ecr = state == S_COMMIT && info.write_ecr && !abort;
        commit_jr  = state == S_COMMIT && info.is_jr && !abort;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (packet_in.valid && !flush) state_n = S_LOCK;
            S_LOCK:     if (ops_ready) state_n = S_READ;
            S_READ:     state_n = S_WAIT_ECR;
            S_WAIT_ECR: if (all_correct) state_n = mem_op ? S_MEM : S_COMMIT;
            S_MEM:      if (granted) state_n = S_RELEASE;
            S_COMMIT:   state_n = S_RELEASE;
            S_RELEASE:  state_n = S_IDLE;
        endcase
        if (abort)
            state_n = S_RELEASE;
    end

    // Reset also masks req_instr so every output reads 0 under reset.
    always_comb begin
        req_instr = rst_n && state == S_IDLE;

        reg_req         = '0;
        reg_req.rs      = (held && info.use_rs) ? pkt_q.phy_rs : '0;
        reg_req.rt      = (held && info.use_rt) ? pkt_q.phy_rt : '0;
        reg_req.waddr   = (held && info.reg_write) ? pkt_q.phy_dst : '0;
        reg_req.wcommit = commit_alu || commit_mem;
        if (commit_mem)
            reg_req.wdata = mem_rdata;
        else if (commit_alu)
            reg_req.wdata = alu_ans.result;

        alu_rpl              = '0;
        alu_rpl.req          = state == S_LOCK && info.use_alu && !alu_held;
        alu_rpl.release_lock = state == S_RELEASE && alu_held;

        alu_req = '0;
        if (alu_held) begin
            alu_req.op = info.alu_op;
            alu_req.a  = rs_q;
            alu_req.b  = rt_q;
        end

        mem_rpl              = '0;
        mem_rpl.req          = mem_on;
        mem_rpl.release_lock = granted;

        mem_req = '0;
        if (state == S_MEM) begin
            mem_req.addr  = addr_q;
            mem_req.wdata = rt_q;
        end
        mem_req.wen = granted && info.mem_write && !abort;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            pkt_q                <= '0;
            rs_q                 <= '0;
            rt_q                 <= '0;
            addr_q               <= '0;
            alu_held             <= 1'b0;
            mem_cnt              <= '0;
            mem_retry_cnt        <= '0;
            ecr_wen              <= 1'b0;
            ecr_waddr            <= '0;
            ecr_wdata            <= '0;
            pc_redirect_valid    <= 1'b0;
            pc_redirect_pc       <= '0;
            pc_redirect_issue_id <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && packet_in.valid && !flush)
                pkt_q <= packet_in;
            if (state == S_READ) begin
                rs_q   <= reg_ans.rs_data;
                rt_q   <= reg_ans.rt_data;
                addr_q <= reg_ans.rs_data + sext16(info.imm);
            end
            if (state == S_RELEASE)
                alu_held <= 1'b0;
            else if (state == S_LOCK && info.use_alu && alu_grant)
                alu_held <= 1'b1;
            // Count only ungranted requesting cycles; the back-off cycle clears.
            if (state != S_MEM || backoff)
                mem_cnt <= '0;
            else if (!mem_grant)
                mem_cnt <= mem_cnt + 1'b1;
            if (state == S_MEM && backoff && mem_retry_cnt != 8'hFF)
                mem_retry_cnt <= mem_retry_cnt + 8'd1;
            ecr_wen   <= commit_ecr;
            ecr_waddr <= commit_ecr ? ECR_AW'(pkt_q.set_ecr_id) : '0;
            if (!commit_ecr)
                ecr_wdata <= '0;
            else if (alu_ans.zero == pkt_q.pred_taken)
                ecr_wdata <= ECR_CORRECT;
            else
                ecr_wdata <= ECR_INCORRECT;
            pc_redirect_valid    <= commit_jr;
            pc_redirect_pc       <= commit_jr ? rs_q : '0;
            pc_redirect_issue_id <= commit_jr ? ID_WIDTH'(pkt_q.issue_id) : '0;
        end
    end

endmodule

// File: tb/tb_instruction_slot_controller.sv
// Directed bench for instruction_slot_controller with a small ALU model.
module tb_instruction_slot_controller;
    import instruction_slot_controller_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_instr;
    sic2_packet_t packet_in;
    reg_req_t     reg_req;
    reg_ans_t     reg_ans;
    pool_rpl_t    mem_rpl;
    mem_req_t     mem_req;
    logic [31:0]  mem_rdata;
    logic         mem_grant;
    pool_rpl_t    alu_rpl;
    alu_req_t     alu_req;
    alu_ans_t     alu_ans;
    logic         alu_grant;
    logic [7:0]   ecr_state;
    logic         ecr_wen;
    logic [1:0]   ecr_waddr;
    logic [1:0]   ecr_wdata;
    logic         flush;
    logic         pc_redirect_valid;
    logic [31:0]  pc_redirect_pc;
    logic [3:0]   pc_redirect_issue_id;
    logic [7:0]   mem_retry_cnt;

    int errors = 0;
    int checks = 0;

    sic2_packet_t p_addu, p_beq, p_lw, p_sw, p_jr;

    instruction_slot_controller #(
        .SIC_ID (0), .NUM_PHY_REGS (64), .ID_WIDTH (4),
        .NUM_ECRS (4), .MEM_TIMEOUT (8)
    ) dut (
        .clk (clk), .rst_n (rst_n), .req_instr (req_instr),
        .packet_in (packet_in), .reg_req (reg_req), .reg_ans (reg_ans),
        .mem_rpl (mem_rpl), .mem_req (mem_req), .mem_rdata (mem_rdata),
        .mem_grant (mem_grant), .alu_rpl (alu_rpl), .alu_req (alu_req),
        .alu_ans (alu_ans), .alu_grant (alu_grant), .ecr_state (ecr_state),
        .ecr_wen (ecr_wen), .ecr_waddr (ecr_waddr), .ecr_wdata (ecr_wdata),
        .flush (flush), .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect_pc (pc_redirect_pc),
        .pc_redirect_issue_id (pc_redirect_issue_id),
        .mem_retry_cnt (mem_retry_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_ans = '0;
        alu_ans.result = (alu_req.op == ALU_SUB) ? alu_req.a - alu_req.b
                                                 : alu_req.a + alu_req.b;
        alu_ans.zero = alu_ans.result == 32'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input sic2_packet_t p);
        packet_in = p;
        packet_in.valid = 1'b1;
        cyc();
        packet_in = '0;
        #1;
    endtask

    function automatic sic2_packet_t mk(
        input logic alu, rs, rt, rw, mr, mw, we, jr,
        input logic [3:0] op, input logic [15:0] imm,
        input logic [5:0] prs, prt, pdst,
        input logic [3:0] mask, input logic [1:0] eid,
        input logic pred, input logic [3:0] id);
        sic2_packet_t p;
        p = '0;
        p.info.use_alu = alu;  p.info.use_rs = rs;   p.info.use_rt = rt;
        p.info.reg_write = rw; p.info.mem_read = mr; p.info.mem_write = mw;
        p.info.write_ecr = we; p.info.is_jr = jr;
        p.info.alu_op = op;    p.info.imm = imm;
        p.phy_rs = prs; p.phy_rt = prt; p.phy_dst = pdst;
        p.dep_ecr_mask = mask; p.set_ecr_id = eid;
        p.pred_taken = pred; p.issue_id = id;
        return p;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; packet_in = '0; reg_ans = '0;
        reg_ans.rs_valid = 1'b1; reg_ans.rt_valid = 1'b1;
        mem_rdata = '0; mem_grant = 1'b0; alu_grant = 1'b1;
        ecr_state = 8'h55; flush = 1'b0;
        p_addu = mk(1,1,1,1,0,0,0,0, ALU_ADD, 16'h0, 6'd3, 6'd4, 6'd5,
                    4'b0010, 2'd0, 1'b0, 4'd1);
        p_beq  = mk(1,1,1,0,0,0,1,0, ALU_SUB, 16'h0, 6'd8, 6'd9, 6'd0,
                    4'b0000, 2'd2, 1'b1, 4'd2);
        p_lw   = mk(0,1,0,1,1,0,0,0, ALU_ADD, 16'hFFFC, 6'd2, 6'd0, 6'd7,
                    4'b0000, 2'd0, 1'b0, 4'd3);
        p_sw   = mk(0,1,1,0,0,1,0,0, ALU_ADD, 16'h0010, 6'd2, 6'd6, 6'd0,
                    4'b0000, 2'd0, 1'b0, 4'd4);
        p_jr   = mk(0,1,0,0,0,0,0,1, ALU_ADD, 16'h0, 6'd31, 6'd0, 6'd0,
                    4'b0000, 2'd0, 1'b0, 4'd9);

        cyc(); cyc();
        chk("rst_req_instr", req_instr, 0);
        chk("rst_reg_req", reg_req, 0);
        chk("rst_pools", {mem_rpl, alu_rpl, mem_req.wen}, 0);
        chk("rst_ecr_pc", {ecr_wen, pc_redirect_valid}, 0);
        chk("rst_retry", mem_retry_cnt, 0);
        rst_n = 1'b1; #1;
        chk("idle_req_instr", req_instr, 1);

        // addu waits on busy ECR1 for three cycles
        ecr_state = 8'h51;
        reg_ans.rs_data = 32'h100; reg_ans.rt_data = 32'h23;
        issue(p_addu);
        chk("lock_busy", req_instr, 0);
        chk("lock_rs_rt", {reg_req.rs, reg_req.rt}, {6'd3, 6'd4});
        chk("lock_alu_req", alu_rpl.req, 1);
        cyc();
        cyc(); chk("wait1_wcommit", reg_req.wcommit, 0);
        cyc(); chk("wait2_wcommit", reg_req.wcommit, 0);
        cyc(); chk("wait3_wcommit", reg_req.wcommit, 0);
        ecr_state = 8'h55;
        cyc();
        chk("addu_commit", {reg_req.wcommit, reg_req.waddr, reg_req.wdata},
            {1'b1, 6'd5, 32'h123});
        cyc();
        chk("addu_release", {alu_rpl.release_lock, reg_req.wcommit}, 2'b10);
        cyc();
        chk("addu_idle", req_instr, 1);

        // beq resolve, rs==rt with predicted taken
        reg_ans.rs_data = 32'h55; reg_ans.rt_data = 32'h55;
        issue(p_beq);
        cyc(); cyc(); cyc();
        chk("beq_commit_noreg", {ecr_wen, reg_req.wcommit}, 0);
        cyc();
        chk("beq_eq_ecr", {ecr_wen, ecr_waddr, ecr_wdata}, {1'b1, 2'd2, 2'b01});
        chk("beq_release_busy", req_instr, 0);
        cyc();
        chk("beq_latency_idle", {req_instr, ecr_wen}, 2'b10);

        reg_ans.rt_data = 32'h56;
        p_beq.set_ecr_id = 2'd3;
        issue(p_beq);
        cyc(); cyc(); cyc(); cyc();
        chk("beq_ne_ecr", {ecr_wen, ecr_waddr, ecr_wdata}, {1'b1, 2'd3, 2'b10});
        cyc();

        // beq aborted by ECR2 turning incorrect
        ecr_state = 8'h45;
        p_beq.dep_ecr_mask = 4'b0100;
        issue(p_beq);
        cyc(); cyc(); cyc();
        chk("abort_wait", {req_instr, reg_req.wcommit}, 0);
        ecr_state = 8'h65;
        cyc();
        chk("abort_release", {alu_rpl.release_lock, ecr_wen, reg_req.wcommit},
            3'b100);
        cyc();
        chk("abort_idle", {req_instr, ecr_wen}, 2'b10);
        ecr_state = 8'h55;

        // packet offered with flush in IDLE is ignored
        packet_in = p_addu; packet_in.valid = 1'b1; flush = 1'b1;
        cyc();
        packet_in = '0; flush = 1'b0; #1;
        chk("idle_flush_ignored", {req_instr, reg_req.rs}, {1'b1, 6'd0});

        // lw with 20 ungranted cycles and back-off
        reg_ans.rs_data = 32'h1000;
        issue(p_lw);
        cyc(); cyc(); cyc();
        chk("lw_addr", mem_req.addr, 32'h0FFC);
        for (int i = 1; i <= 20; i++) begin
            chk($sformatf("lw_req_c%0d", i), mem_rpl.req,
                (i == 9 || i == 18) ? 1'b0 : 1'b1);
            cyc();
        end
        chk("lw_retry_cnt", mem_retry_cnt, 8'd2);
        mem_rdata = 32'hCAFEF00D; mem_grant = 1'b1; #1;
        chk("lw_commit", {reg_req.wcommit, reg_req.waddr, reg_req.wdata},
            {1'b1, 6'd7, 32'hCAFEF00D});
        chk("lw_lock", {mem_rpl.release_lock, mem_req.wen}, 2'b10);
        cyc();
        mem_grant = 1'b0; #1;
        chk("lw_release", {req_instr, reg_req.wcommit, mem_rpl.req}, 0);
        cyc();

        // sw with flush colliding with grant
        reg_ans.rs_data = 32'h2000; reg_ans.rt_data = 32'hAB;
        issue(p_sw);
        cyc(); cyc(); cyc();
        mem_grant = 1'b1; #1;
        chk("sw_wen_noflush", {mem_req.wen, mem_req.addr, mem_req.wdata},
            {1'b1, 32'h2010, 32'hAB});
        flush = 1'b1; #1;
        chk("sw_wen_flush", mem_req.wen, 0);
        cyc();
        flush = 1'b0; mem_grant = 1'b0; #1;
        chk("sw_release", {req_instr, mem_rpl.req}, 0);
        cyc();
        chk("sw_idle", req_instr, 1);

        // jr redirect pulse
        reg_ans.rs_data = 32'h00400020;
        issue(p_jr);
        cyc(); cyc(); cyc();
        chk("jr_commit_nopulse", pc_redirect_valid, 0);
        cyc();
        chk("jr_redirect", {pc_redirect_valid, pc_redirect_pc, pc_redirect_issue_id},
            {1'b1, 32'h00400020, 4'd9});
        cyc();
        chk("jr_pulse_end", pc_redirect_valid, 0);

        // reset during COMMIT
        reg_ans.rs_data = 32'h100; reg_ans.rt_data = 32'h23;
        p_addu.dep_ecr_mask = 4'b0000;
        issue(p_addu);
        cyc(); cyc(); cyc();
        chk("midrst_commit", reg_req.wcommit, 1);
        rst_n = 1'b0;
        cyc();
        chk("midrst_req_instr", req_instr, 0);
        chk("midrst_reg_req", reg_req, 0);
        chk("midrst_pools", {alu_rpl, mem_rpl}, 0);
        chk("midrst_pulses", {ecr_wen, pc_redirect_valid}, 0);
        chk("midrst_retry", mem_retry_cnt, 0);
        rst_n = 1'b1; #1;
        chk("midrst_idle", req_instr, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_slot_controller.md
INSTRUCTION_SLOT_CONTROLLER -- requirements
Module: instruction_slot_controller

Interface
REQ-001 Parameter SIC_ID, default 0, slot index used only in simulation messages.
REQ-002 Parameter NUM_PHY_REGS, default 64, physical register count; PR address width is $clog2(NUM_PHY_REGS).
REQ-003 Parameter ID_WIDTH, default 4, width of the issue id.
REQ-004 Parameter NUM_ECRS, default 4 (>=1), number of ECRs; one dependency bit per ECR.
REQ-005 Parameter MEM_TIMEOUT, default 8 (>=1), number of consecutive ungranted MEM cycles before a back-off.
REQ-006 Clocking is one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 req_instr  out  1  slot is free and can accept a packet this cycle.
REQ-010 packet_in  in  sic2_packet_t  issued packet: valid, issue_id, pc, phy_rs/rt/dst, dep_ecr_mask[NUM_ECRS], set_ecr_id, pred_taken, info.
REQ-011 reg_req / reg_ans  out/in  packed  RF read/write interface, same fields as the current RF port.
REQ-012 mem_rpl, mem_req / mem_rdata, mem_grant  out/in  packed, 32, 1  memory pool lock and access.
REQ-013 alu_rpl, alu_req / alu_ans, alu_grant  out/in  packed, 1  ALU pool lock and operands.
REQ-014 ecr_state  in  NUM_ECRS x 2  live state of every ECR (00 Busy, 01 Correct, 10 Incorrect).
REQ-015 ecr_wen, ecr_waddr, ecr_wdata  out  1, $clog2(NUM_ECRS), 2  ECR resolve write.
REQ-016 flush  in  1  global squash; kills any held instruction.
REQ-017 pc_redirect_valid, pc_redirect_pc, pc_redirect_issue_id  out  1, 32, ID_WIDTH  JR redirect pulse.
REQ-018 mem_retry_cnt  out  8  saturating count of MEM back-offs since reset.

Function
REQ-019 States: IDLE, LOCK, READ, WAIT_ECR, MEM, COMMIT, RELEASE.
REQ-020 IDLE: req_instr=1; packet_in.valid latches the packet and moves to LOCK on the same edge (no separate wait state).
REQ-021 LOCK: request the ALU if info.use_alu; move to READ when rs_valid/rt_valid (where needed) and alu_grant (where needed) are all true.
REQ-022 READ: exactly one cycle; sample operands, compute byte address rs+sign_ext(imm16), and capture the JR target.
REQ-023 WAIT_ECR: dep = ecr_state masked by dep_ecr_mask; proceed when every masked ECR is 01 or the mask is empty.
REQ-024 From WAIT_ECR, go to MEM for mem_read/mem_write, otherwise to COMMIT.
REQ-025 Abort: a masked ECR equal to 10, or flush=1, in any state other than IDLE/RELEASE forces RELEASE next cycle.
REQ-026 While aborting, suppress wcommit, mem wen, ecr_wen and pc_redirect in that cycle.
REQ-027 MEM: assert mem_rpl.req.
REQ-028 On mem_grant in MEM, release the lock the same cycle; sw writes, lw commits mem_rdata to phy_dst; then go to RELEASE.
REQ-029 MEM back-off: after MEM_TIMEOUT consecutive ungranted cycles, drop req for one cycle, reset the counter, and increment mem_retry_cnt (saturating at 255).
REQ-030 COMMIT: one cycle; wcommit for non-memory writers.
REQ-031 COMMIT with write_ecr: ecr_wen=1 at set_ecr_id; ecr_wdata=01 if (alu zero==pred_taken), else 10.
REQ-032 COMMIT with JR: pulse pc_redirect for one cycle.
REQ-033 Output registering: ecr_wen and pc_redirect are registered pulses, asserted the cycle after COMMIT.
REQ-034 RELEASE: pulse alu_rpl.release_lock if the ALU was held, then go to IDLE; minimum latency for an ALU op is IDLE to IDLE in 6 cycles.
REQ-035 PR occupancy: rs/rt/waddr are driven only while a packet is held and the field is needed, else 0.
REQ-036 Simultaneous events: flush and mem_grant in the same cycle means flush wins and no write occurs; flush in IDLE is ignored and a packet presented with flush=1 is not accepted.

Reset
REQ-037 On rst_n=0 at a clock edge: state=IDLE and every output 0, including mem_retry_cnt.
REQ-038 Reset mid-operation discards the packet without any release or commit pulse.

Structure
REQ-039 sic2_packet_t, the ECR encoding constants and the state enum live in the shared structs package.
REQ-040 A sub-module ecr_dep_checker (mask, ecr_state → all_correct, any_incorrect) is combinational and reused by other slots.

Verification
REQ-041 Dependency resolve: addu with mask=0b0010, ECR1=00 for 3 cycles then 01 → stays in WAIT_ECR 3 cycles, then wcommit of rs+rt.
REQ-042 Abort by ECR: beq with ECR2 set to 10 while in WAIT_ECR → RELEASE; no ecr_wen, no wcommit; alu release pulse.
REQ-043 Branch resolve: beq, pred_taken=1, rs==rt → ecr_wen with ecr_wdata=01 at set_ecr_id; with rs!=rt → 10.
REQ-044 Memory back-off: lw with mem_grant held low 20 cycles, MEM_TIMEOUT=8 → req drops at cycles 9 and 18, mem_retry_cnt=2; grant then yields wcommit of mem_rdata.
REQ-045 Flush/grant collision: sw with flush and mem_grant asserted in the same cycle → mem_req.wen=0, next state RELEASE.
REQ-046 Mid-op reset and JR: rst_n low during COMMIT → all outputs 0 next cycle; JR rs=0x00400020 → one-cycle pc_redirect with pc=0x00400020 and the matching issue_id.
